gcd_host_sequencer: RTL
=======================

Name: gcd_host_sequencer

Overview:
- Host-side driver for the GCD unit's In_ready/Result_taken handshake. It is the initiator end of the protocol that the GCD control FSM answers.
- Accepts operand pairs from an upstream valid/ready port and presents them to the GCD unit with a one-cycle In_ready pulse.
- Waits for the result, acknowledges it with a one-cycle Result_taken pulse, then returns it on a downstream valid/ready port.
- Includes a watchdog timeout and a transaction counter.

Parameters:
- W, 16, operand/result width in bits
- TIMEOUT, 255, maximum cycles spent in WAIT before an error response (must be >= 1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  upstream operand pair valid
- req_ready  output  1  sequencer can accept an operand pair
- req_a  input  W  operand A
- req_b  input  W  operand B
- rsp_valid  output  1  response valid
- rsp_ready  input  1  downstream accepts response
- rsp_gcd  output  W  GCD result (0 on error)
- rsp_err  output  1  response is a timeout error
- gcd_a  output  W  operand A to GCD unit
- gcd_b  output  W  operand B to GCD unit
- gcd_in_ready  output  1  In_ready pulse to GCD unit
- gcd_result_valid  input  1  GCD unit is in DONE with result on gcd_result
- gcd_result  input  W  GCD unit result data
- gcd_result_taken  output  1  Result_taken pulse to GCD unit
- xact_count  output  8  completed-response counter

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset state: state=IDLE; gcd_a=0, gcd_b=0, rsp_gcd=0, rsp_err=0, xact_count=0, WAIT timer=0.
- Reset outputs: gcd_in_ready=0, gcd_result_taken=0, rsp_valid=0, req_ready=1 (IDLE decode).
- Moore FSM: control outputs decode from the state register only, with no combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT, TAKE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_a into gcd_a and req_b into gcd_b, then go to ISSUE.
- ISSUE:
  - gcd_in_ready=1 for exactly one cycle.
  - Clear the timer, then go to WAIT.
- WAIT:
  - If gcd_result_valid: capture gcd_result into rsp_gcd, set rsp_err=0, go to TAKE.
  - Else if timer==TIMEOUT-1: set rsp_gcd=0, set rsp_err=1, go to RESP (skip TAKE, so no Result_taken).
  - Else: timer increments.
  - If result valid and timeout occur in the same cycle, the result wins.
- TAKE: gcd_result_taken=1 for exactly one cycle, then go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_gcd and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake: xact_count increments (mod 256, 255 wraps to 0; error responses counted), then go to IDLE.
- req_ready=0 in every state except IDLE, so at most one transaction is outstanding.
- gcd_a and gcd_b are held constant from ISSUE through TAKE. They change only on a new accept in IDLE.
- Latency for accept at edge 0 with the result seen in WAIT at cycle k:
  - ISSUE in cycle 1.
  - WAIT from cycle 2.
  - TAKE in cycle k+1.
  - rsp_valid from cycle k+2.
- Minimum accept-to-rsp_valid latency is 4 cycles (result valid in the first WAIT cycle).
- Reset asserted in any state: next edge forces IDLE and all reset values, including xact_count=0. Any pending pulse is dropped.

Optional Feature:
- Macro: GCD_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, an accepted pair with req_a==0 or req_b==0 bypasses the GCD unit.
  - rsp_gcd=req_a|req_b (gcd(0,0)=0), rsp_err=0, next state RESP.
  - No gcd_in_ready or gcd_result_taken pulse occurs, and gcd_a/gcd_b are left unchanged.
  - rsp_valid is asserted in the cycle after accept.
- Undefined: all pairs, including zero operands, take the full ISSUE/WAIT/TAKE path.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: all outputs at reset values, req_ready=1, xact_count=0.
- Nominal:
  - Stimulus: req (48,18); model raises gcd_result_valid with gcd_result=6 in the 5th WAIT cycle.
  - Required: exactly one gcd_in_ready pulse with gcd_a=48, gcd_b=18; one gcd_result_taken pulse; rsp_gcd=6, rsp_err=0; xact_count=1.
- Backpressure:
  - Stimulus: after the nominal case, rsp_ready=0 for 4 cycles while req_valid=1 with (21,14).
  - Required: rsp_valid=1 and rsp_gcd=6 stable; req_ready=0; the (21,14) pair is accepted only after the response handshake and yields 7.
- Timeout:
  - Stimulus: TIMEOUT=8; model never asserts result valid.
  - Required: rsp_valid after 8 WAIT cycles with rsp_err=1, rsp_gcd=0; no gcd_result_taken pulse; xact_count increments.
- Reset mid-operation:
  - Stimulus: rst=1 for 1 cycle during WAIT.
  - Required: IDLE next cycle, xact_count=0, no rsp_valid, no gcd_result_taken; a following request (9,6) completes with 3.
- Zero operand:
  - Stimulus: req (0,35).
  - Required with GCD_ZERO_BYPASS_EN defined: rsp_valid the cycle after accept, rsp_gcd=35, no gcd_in_ready pulse.
  - Required without the macro: normal path with an in_ready pulse, gcd_a=0, gcd_b=35.

Source files
------------

// File: rtl/gcd_host_sequencer.sv
// Host-side initiator for the GCD unit In_ready/Result_taken handshake, with watchdog and response counter.
// Optional build macro GCD_ZERO_BYPASS_EN: zero-operand pairs are answered locally without touching the GCD unit.
module gcd_host_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_gcd,
  output logic         rsp_err,
  output logic [W-1:0] gcd_a,
  output logic [W-1:0] gcd_b,
  output logic         gcd_in_ready,
  input  logic         gcd_result_valid,
  input  logic [W-1:0] gcd_result,
  output logic         gcd_result_taken,
  output logic [7:0]   xact_count
);

  // Timer only ever needs to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_TAKE, S_RESP
  } state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_gcd_a, r_gcd_b, r_rsp_gcd;
  logic          r_rsp_err;
  logic [7:0]    r_count;
  logic [TW-1:0] r_timer;
  logic          w_bypass;
  logic          w_timeout;

`ifdef GCD_ZERO_BYPASS_EN
  assign w_bypass = (req_a == '0) || (req_b == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state plus Moore output decode; outputs depend on r_state only.
  always_comb begin
    w_next           = r_state;
    req_ready        = 1'b0;
    gcd_in_ready     = 1'b0;
    gcd_result_taken = 1'b0;
    rsp_valid        = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_bypass ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        gcd_in_ready = 1'b1;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        if (gcd_result_valid) w_next = S_TAKE;
        else if (w_timeout)   w_next = S_RESP;
      end
      S_TAKE: begin
        gcd_result_taken = 1'b1;
        w_next           = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gcd_a   <= '0;
      r_gcd_b   <= '0;
      r_rsp_gcd <= '0;
      r_rsp_err <= 1'b0;
      r_count   <= '0;
      r_timer   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_bypass) begin
              // gcd(0,x)=x and gcd(0,0)=0, so OR gives the answer directly.
              r_rsp_gcd <= req_a | req_b;
              r_rsp_err <= 1'b0;
            end else begin
              r_gcd_a <= req_a;
              r_gcd_b <= req_b;
            end
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          if (gcd_result_valid) begin
            r_rsp_gcd <= gcd_result;
            r_rsp_err <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_gcd <= '0;
            r_rsp_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: if (rsp_ready) r_count <= r_count + 8'd1;
        default: ;
      endcase
    end
  end

  assign gcd_a      = r_gcd_a;
  assign gcd_b      = r_gcd_b;
  assign rsp_gcd    = r_rsp_gcd;
  assign rsp_err    = r_rsp_err;
  assign xact_count = r_count;

endmodule
